radiant_coinc_trig: RTL and testbench

// Programmable N-of-M coincidence trigger for one RADIANT trigger unit.
// Per-channel discriminator hits (24 channels, already synchronized to clk_i

---
 rtl/radiant_coinc_trig.sv | 99 +++++++++
 tb/tb_radiant_coinc_trig.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/radiant_coinc_trig.sv
// N-of-M coincidence trigger: masked hits are stretched into a programmable window, counted,
// and a single-clock trigger pulse fires on the rising edge of (count > threshold).
module radiant_coinc_trig #(
    parameter int unsigned NCHAN  = 24,
    parameter int unsigned WFIELD = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [NCHAN-1:0]             chan_en_i,
    input  logic [NCHAN-1:0]             chmask_i,
    input  logic [3*WFIELD-1:0]          window_i,
    input  logic [$clog2(NCHAN+1)-1:0]   thresh_i,
    input  logic [NCHAN-1:0]             trig_i,
    output logic                         trig_o,
    output logic [NCHAN-1:0]             trig_chans_o,
    output logic [$clog2(NCHAN+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(NCHAN + 1);
    localparam int unsigned WW = WFIELD + 2;

    logic [WW-1:0]    win_len;
    logic [WW-1:0]    cnt_q [NCHAN];
    logic [WW-1:0]    cnt_d [NCHAN];
    logic [NCHAN-1:0] active;
    logic [CW-1:0]    cnt_sum;
    logic [CW-1:0]    count_q;
    logic [NCHAN-1:0] act_d_q;
    logic             over_q;
    logic             over_d_q;
    logic             trig_q;
    logic             trig_d;
    logic [NCHAN-1:0] trig_chans_q;

    always_comb begin
        win_len = WW'(1)
                + WW'(window_i[WFIELD-1:0])
                + WW'(window_i[2*WFIELD-1:WFIELD])
                + WW'(window_i[3*WFIELD-1:2*WFIELD]);
    end

    // Window length is captured only on load, so a running window is never resized.
    always_comb begin
        for (int unsigned k = 0; k < NCHAN; k++) begin
            if (!en_i || !chan_en_i[k] || !chmask_i[k]) begin
                cnt_d[k] = '0;
            end else if (trig_i[k]) begin
                cnt_d[k] = win_len;
            end else if (cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - WW'(1);
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    always_comb begin
        cnt_sum = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            active[k] = (cnt_q[k] != '0);
            cnt_sum   = cnt_sum + CW'(active[k]);
        end
    end

    assign trig_d = en_i & over_q & ~over_d_q;

    // Count and snapshot are also cleared while disabled so re-enable cannot fire on stale hits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NCHAN; k++) begin
                cnt_q[k] <= '0;
            end
            count_q      <= '0;
            act_d_q      <= '0;
            over_q       <= 1'b0;
            over_d_q     <= 1'b0;
            trig_q       <= 1'b0;
            trig_chans_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NCHAN; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            count_q  <= en_i ? cnt_sum : '0;
            act_d_q  <= en_i ? active : '0;
            over_q   <= en_i & (count_q > thresh_i);
            over_d_q <= over_q;
            trig_q   <= trig_d;
            if (trig_d) begin
                trig_chans_q <= act_d_q;
            end
        end
    end

    assign trig_o       = trig_q;
    assign trig_chans_o = trig_chans_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_radiant_coinc_trig.sv
// Directed bench for radiant_coinc_trig: expected trigger snapshots are queued when hits
// are driven and compared by a monitor whenever trig_o pulses.
module tb_radiant_coinc_trig;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] chan_en;
    logic [23:0] chmask;
    logic [14:0] window;
    logic [4:0]  thresh;
    logic [23:0] trig_in;
    logic        trig_out;
    logic [23:0] trig_chans;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;
    int ntrig  = 0;
    int peak   = 0;
    int base;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    radiant_coinc_trig #(.NCHAN(24), .WFIELD(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .chan_en_i    (chan_en),
        .chmask_i     (chmask),
        .window_i     (window),
        .thresh_i     (thresh),
        .trig_i       (trig_in),
        .trig_o       (trig_out),
        .trig_chans_o (trig_chans),
        .count_o      (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every trigger pulse must match the oldest queued snapshot.
    always @(negedge clk) begin
        if (!rst && (int'(count) > peak)) peak = int'(count);
        if (!rst && trig_out === 1'b1) begin
            ntrig++;
            chk("trig_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("trig_chans", 32'(trig_chans), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [23:0] ch);
        trig_in = ch;
        idle(1);
        trig_in = '0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            idle(1);
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; chan_en = 24'hFFFFFF; chmask = 24'hFFFFFF;
        window = 15'((11 << 10) | (31 << 5) | 31); thresh = 5'd2; trig_in = '0;
        idle(3);
        chk("reset_trig", 32'(trig_out), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_chans", 32'(trig_chans), 32'd0);
        rst = 1'b0;
        idle(2);

        // 1: three hits within W=74 -> single trigger 3 clocks after third hit
        base = ntrig;
        pulse(24'h1); idle(9);
        pulse(24'h2); idle(9);
        exp_q.push_back(24'h000007);
        pulse(24'h4);
        idle(2);
        chk("t1_no_early_trig", 32'(trig_out), 32'd0);
        chk("t1_count", 32'(count), 32'd3);
        idle(1);
        chk("t1_trig_latency", 32'(trig_out), 32'd1);
        idle(1);
        chk("t1_one_clock", 32'(trig_out), 32'd0);
        idle(80);
        chk("t1_count_clear", 32'(count), 32'd0);
        chk("t1_ntrig", 32'(ntrig - base), 32'd1);

        // 2: ch0 expires before ch2 arrives
        base = ntrig; peak = 0;
        pulse(24'h1); idle(9);
        pulse(24'h2); idle(69);
        pulse(24'h4); idle(5);
        chk("t2_peak", 32'(peak), 32'd2);
        chk("t2_ntrig", 32'(ntrig - base), 32'd0);
        idle(100);

        // 3: ch1 excluded by coincidence mask
        base = ntrig; chmask = 24'hFFFFFD;
        pulse(24'h7); idle(6);
        chk("t3_masked_count", 32'(count), 32'd2);
        exp_q.push_back(24'h00000D);
        pulse(24'h8);
        drain("t3_trig", 10);
        chk("t3_ntrig", 32'(ntrig - base), 32'd1);
        idle(100);
        chmask = 24'hFFFFFF;

        // 4: all channels at once, thresh 23 fires, 24 never fires
        base = ntrig; thresh = 5'd23;
        exp_q.push_back(24'hFFFFFF);
        pulse(24'hFFFFFF);
        idle(2);
        chk("t4_no_early_trig", 32'(trig_out), 32'd0);
        chk("t4_count_all", 32'(count), 32'd24);
        idle(1);
        chk("t4_trig_latency", 32'(trig_out), 32'd1);
        idle(100);
        thresh = 5'd24;
        pulse(24'hFFFFFF); idle(3);
        chk("t4_count_all_again", 32'(count), 32'd24);
        idle(10);
        chk("t4_ntrig", 32'(ntrig - base), 32'd1);
        idle(100);

        // 5: held condition gives one pulse; re-arm after window drains
        base = ntrig; thresh = 5'd2;
        exp_q.push_back(24'h000007);
        trig_in = 24'h7;
        idle(200);
        trig_in = '0;
        chk("t5_held_ntrig", 32'(ntrig - base), 32'd1);
        idle(77);
        exp_q.push_back(24'h000007);
        pulse(24'h7);
        drain("t5_rearm_trig", 10);
        idle(3);
        chk("t5_ntrig", 32'(ntrig - base), 32'd2);
        idle(100);

        // 6a: disable clears pending hits
        base = ntrig;
        pulse(24'h3); idle(2);
        en = 1'b0; idle(1);
        en = 1'b1;
        pulse(24'h4); idle(5);
        chk("t6_en_count", 32'(count), 32'd1);
        chk("t6_en_ntrig", 32'(ntrig - base), 32'd0);
        idle(100);

        // 6b: reset mid-window behaves like power-up
        pulse(24'h3); idle(2);
        rst = 1'b1; idle(1);
        chk("t6_rst_chans", 32'(trig_chans), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        pulse(24'h4); idle(5);
        chk("t6_rst_count_after", 32'(count), 32'd1);
        chk("t6_rst_ntrig", 32'(ntrig - base), 32'd0);
        idle(100);

        // 7: thresh 0 fires on a single hit; channel-enable mask gates inputs
        base = ntrig; thresh = 5'd0; chan_en = 24'hFFFFFE;
        pulse(24'h1); idle(6);
        chk("t7_chan_en_count", 32'(count), 32'd0);
        exp_q.push_back(24'h000002);
        pulse(24'h2);
        drain("t7_single_hit_trig", 10);
        chk("t7_ntrig", 32'(ntrig - base), 32'd1);
        idle(5);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
